// File: rtl/bram_model_be.sv
// bram_model_be: true-dual-port block-RAM model with byte lanes,
// read-during-write modes, optional output stage and zeroing sweep.
module bram_model_be #(
   parameter int data_w  = 36,
   parameter int addr_w  = 10,
   parameter int byte_w  = 9,
   parameter int rd_mode = 0,
   parameter int out_reg = 0
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     ENA,
   input  logic                     ENB,
   input  logic [data_w/byte_w-1:0] WEA,
   input  logic [data_w/byte_w-1:0] WEB,
   input  logic                     SSRA,
   input  logic                     SSRB,
   input  logic [addr_w-1:0]        ADDRA,
   input  logic [addr_w-1:0]        ADDRB,
   input  logic [data_w-1:0]        DIA,
   input  logic [data_w-1:0]        DIB,
   output logic [data_w-1:0]        DOA,
   output logic [data_w-1:0]        DOB,
   output logic                     READY,
   output logic                     COLL
);

   localparam int NB    = data_w / byte_w;
   localparam int DEPTH = 2 ** addr_w;
   localparam int RF    = 0;
   localparam int WF    = 1;
   localparam logic [addr_w:0] LAST = {1'b0, {addr_w{1'b1}}};

   typedef enum logic {CLEAR, RUN} state_e;

   state_e state_q, state_d;
   logic [addr_w:0] cnt_q, cnt_d;
   logic ready_q, ready_d;
   logic clr_we;
   logic run;

   logic [data_w-1:0] mem [DEPTH];

   logic wr_a, wr_b, same, ovl;
   logic [data_w-1:0] old_a, old_b;
   logic [data_w-1:0] wf_a, wf_b, mw_a;

   logic [data_w-1:0] s1a_q, s1a_d, s1b_q, s1b_d;
   logic [data_w-1:0] s2a_q, s2a_d, s2b_q, s2b_d;
   logic coll_q, coll_d;

   // Replace the lanes selected by we with di, keep the rest of old.
   function automatic logic [data_w-1:0] merge(
      input logic [data_w-1:0] old,
      input logic [data_w-1:0] di,
      input logic [NB-1:0]     we
   );
      logic [data_w-1:0] r;
      r = old;
      for (int i = 0; i < NB; i++) begin
         if (we[i]) r[i*byte_w +: byte_w] = di[i*byte_w +: byte_w];
      end
      return r;
   endfunction

   // Stage-1 next value for one port given its read-during-write mode.
   function automatic logic [data_w-1:0] s1_nxt(
      input logic [data_w-1:0] cur,
      input logic              en,
      input logic              wr,
      input logic              ssr,
      input logic [data_w-1:0] pre,
      input logic [data_w-1:0] post
   );
      logic [data_w-1:0] r;
      r = cur;
      if (en) begin
         if (rd_mode == RF)      r = pre;
         else if (rd_mode == WF) r = post;
         else if (!wr)           r = pre;
      end
      if (ssr && out_reg == 0) r = '0;
      return r;
   endfunction

   assign run = (state_q == RUN);

   // Sweep controller: clear every word once, then hand over to RUN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      clr_we  = 1'b0;
      unique case (state_q)
         CLEAR: begin
            clr_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = RUN;
               ready_d = 1'b1;
            end
         end
         RUN: ready_d = 1'b1;
         default: state_d = CLEAR;
      endcase
   end

   // Sweep state, counter and ready flag.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   assign old_a = mem[ADDRA];
   assign old_b = mem[ADDRB];
   assign wr_a  = run & ENA & (|WEA);
   assign wr_b  = run & ENB & (|WEB);
   assign same  = (ADDRA == ADDRB);
   assign ovl   = wr_a & wr_b & same & (|(WEA & WEB));
   assign wf_a  = merge(old_a, DIA, WEA);
   assign wf_b  = merge(old_b, DIB, WEB);
   // On a same-address write, A lanes overlay B's merged word.
   assign mw_a  = (same && wr_b) ? merge(wf_b, DIA, WEA) : wf_a;

   // Memory array: sweep zeroing or port writes, A wins overlaps.
   always_ff @(posedge CLK) begin
      if (clr_we) begin
         if (RST_N) mem[cnt_q[addr_w-1:0]] <= '0;
      end else begin
         if (wr_b && !(wr_a && same)) mem[ADDRB] <= wf_b;
         if (wr_a) mem[ADDRA] <= mw_a;
      end
   end

   // Output pipeline next values; everything holds outside RUN.
   always_comb begin
      s1a_d  = s1a_q;
      s1b_d  = s1b_q;
      s2a_d  = s2a_q;
      s2b_d  = s2b_q;
      coll_d = 1'b0;
      if (run) begin
         s1a_d  = s1_nxt(s1a_q, ENA, |WEA, SSRA, old_a, wf_a);
         s1b_d  = s1_nxt(s1b_q, ENB, |WEB, SSRB, old_b, wf_b);
         s2a_d  = SSRA ? '0 : s1a_q;
         s2b_d  = SSRB ? '0 : s1b_q;
         coll_d = ovl;
      end
   end

   // Output pipeline and collision flag registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1a_q  <= '0;
         s1b_q  <= '0;
         s2a_q  <= '0;
         s2b_q  <= '0;
         coll_q <= 1'b0;
      end else begin
         s1a_q  <= s1a_d;
         s1b_q  <= s1b_d;
         s2a_q  <= s2a_d;
         s2b_q  <= s2b_d;
         coll_q <= coll_d;
      end
   end

   assign DOA   = (out_reg != 0) ? s2a_q : s1a_q;
   assign DOB   = (out_reg != 0) ? s2b_q : s1b_q;
   assign READY = ready_q;
   assign COLL  = coll_q;

endmodule
